oam_dma_ctrl: RTL
=================

// Module: oam_dma_ctrl
// PURPOSE
//  Sprite DMA sequencer ($4014) sitting between the CPU core and WRAM_mapper.
//  On a CPU write to DMA_REG_ADDR it halts the CPU and takes ownership of the
//  CPU bus: XFER_LEN read/write pairs copy page {data,8'h00..FF} to the PPU
//  OAM data register. When idle the CPU bus is passed through unchanged.
// PARAMETERS
//  DMA_REG_ADDR   16'h4014  CPU address whose write triggers a transfer
//  OAM_DATA_ADDR  16'h2004  destination address for every DMA write cycle
//  XFER_LEN       256       bytes per transfer (1..256; low byte of source addr)
// PORTS
//  clk          in   1   system clock (CPU bus rate)
//  reset        in   1   asynchronous, active-high reset
//  cpu_addr     in   16  CPU address bus
//  cpu_WE       in   1   CPU write enable
//  cpu_data_out in   8   CPU write data
//  bus_rdata    in   8   read data from mapper (data_out), combinational same cycle
//  bus_addr     out  16  address to mapper
//  bus_WE       out  1   write enable to mapper
//  bus_wdata    out  8   write data to mapper / PPU regs
//  cpu_halt     out  1   1 = CPU must stall (no fetch, no bus drive)
//  dma_active   out  1   1 = DMA owns bus (state != IDLE)
//  dma_done     out  1   1-cycle pulse on last OAM write
// BEHAVIOUR
//  - Reset (async): state=IDLE, idx=0, page=0, byte_q=0, cyc_odd=0;
//    cpu_halt=0, dma_active=0, dma_done=0; bus outputs follow pass-through.
//  - cyc_odd: free-running flop, toggles every clk from reset.
//  - States: IDLE, HALT, ALIGN, READ, WRITE.
//  - IDLE: bus_addr=cpu_addr, bus_WE=cpu_WE, bus_wdata=cpu_data_out.
//    cpu_WE && cpu_addr==DMA_REG_ADDR at edge: page<=cpu_data_out, idx<=0,
//    -> HALT. The trigger write itself passes through to the mapper.
//  - HALT (1 cycle): cpu_halt=1, bus_WE=0, bus_addr=cpu_addr (dummy read).
//    -> ALIGN if cyc_odd==1 (ALIGN_EN), else -> READ.
//  - ALIGN (1 cycle): as HALT; -> READ. Guarantees first READ when cyc_odd==0.
//  - READ: bus_addr={page,idx}, bus_WE=0; byte_q<=bus_rdata at edge; -> WRITE.
//  - WRITE: bus_addr=OAM_DATA_ADDR, bus_WE=1, bus_wdata=byte_q.
//    idx==XFER_LEN-1: dma_done=1 (comb, this cycle), -> IDLE, idx<=0;
//    else idx<=idx+1, -> READ.
//  - cpu_halt=dma_active=1 in all non-IDLE states; cpu_halt drops the cycle
//    after the final WRITE; CPU resumes on next edge.
//  - Latency: trigger write cycle T; halt T+1..T+513 (even) or T+514 (odd).
//  - idx is 8 bits; no wrap past XFER_LEN-1; source page never increments.
//  - CPU inputs ignored while non-IDLE (incl. further DMA_REG_ADDR writes).
//  - Source page $20-$3F reads PPU regs via mapper: permitted, no special case.
//  - reset mid-transfer: immediate IDLE, cpu_halt=0, no dma_done, partial OAM
//    contents left as written.
// CONFIGURATION
//  OAM_DMA_ALIGN_EN defined: ALIGN state inserted when HALT sees cyc_odd==1
//   (513 or 514 halt cycles, hardware-accurate).
//  Not defined: ALIGN never entered; always 513 halt cycles, cyc_odd unused.
// TESTING
//  1 Pass-through: idle, CPU write $0005<=8'hA5 -> bus_addr=16'h0005,
//    bus_WE=1, bus_wdata=8'hA5 same cycle, cpu_halt=0.
//  2 Full copy: RAM $0200..$02FF=idx^8'h5A, write $4014<=8'h02 on even cycle
//    -> 256 writes to $2004 with data idx^8'h5A in order, halt 513 cycles,
//    one dma_done pulse on 256th write.
//  3 Parity (ALIGN_EN): trigger so HALT sees cyc_odd=1 -> 514 halt cycles,
//    first READ addr $0200 with cyc_odd=0; without macro -> 513.
//  4 Retrigger: write $4014 again during transfer -> ignored, count unchanged.
//  5 Reset at byte 100 -> next cycle state IDLE, cpu_halt=0, dma_done never
//    pulses; subsequent $4014<=8'h03 runs full clean 256-byte transfer.
//  6 Back-to-back: trigger on first CPU cycle after dma_done -> new transfer
//    starts, no lost or duplicated OAM write.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite DMA sequencer for the $4014 register. Sits between the CPU core and
// the WRAM mapper. A CPU write to DMA_REG_ADDR latches a source page, halts
// the CPU and copies XFER_LEN bytes from {page, 8'h00..} into the PPU OAM data
// register using alternating READ / WRITE bus cycles. While idle, the CPU bus
// is passed straight through to the mapper.
//
// Build option:
//   OAM_DMA_ALIGN_EN  When defined, an ALIGN cycle is inserted after HALT if
//                     the free-running cycle-parity flop is odd at that time
//                     (513 or 514 halt cycles). When undefined, ALIGN is never
//                     entered and every transfer halts the CPU for 513 cycles.
//
// Ports:
//   clk           in   1   system clock (CPU bus rate)
//   reset         in   1   asynchronous, active-high reset
//   cpu_addr      in   16  CPU address bus
//   cpu_WE        in   1   CPU write enable
//   cpu_data_out  in   8   CPU write data
//   bus_rdata     in   8   mapper read data (combinational, same cycle)
//   bus_addr      out  16  address to mapper
//   bus_WE        out  1   write enable to mapper
//   bus_wdata     out  8   write data to mapper / PPU registers
//   cpu_halt      out  1   CPU must stall
//   dma_active    out  1   DMA owns the bus
//   dma_done      out  1   one-cycle pulse on the final OAM write
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_WE,
    input  logic [7:0]  cpu_data_out,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_WE,
    output logic [7:0]  bus_wdata,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // Index of the last byte; idx never counts past it, so no wrap handling.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q,   idx_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  byte_q,  byte_d;
    logic        halt_q;
`ifdef OAM_DMA_ALIGN_EN
    logic        cyc_odd_q;
`endif

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                // The trigger write still reaches the mapper via pass-through.
                if (cpu_WE && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_data_out;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                if (cyc_odd_q) begin
                    state_d = S_ALIGN;
                end else begin
                    state_d = S_READ;
                end
`else
                state_d = S_READ;
`endif
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                byte_d  = bus_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'h00;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus steering: pass-through when idle, DMA-driven otherwise.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_WE    = cpu_WE;
        bus_wdata = cpu_data_out;
        dma_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus_WE = cpu_WE;
            end
            S_HALT, S_ALIGN: begin
                // Dummy read of whatever the stalled CPU presents.
                bus_WE = 1'b0;
            end
            S_READ: begin
                bus_addr = {page_q, idx_q};
                bus_WE   = 1'b0;
            end
            S_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_WE    = 1'b1;
                bus_wdata = byte_q;
                dma_done  = (idx_q == LAST_IDX);
            end
            default: begin
                bus_WE = cpu_WE;
            end
        endcase
    end

    // State registers, registered halt flag and cycle-parity flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'h00;
            page_q    <= 8'h00;
            byte_q    <= 8'h00;
            halt_q    <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            cyc_odd_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            page_q    <= page_d;
            byte_q    <= byte_d;
            // Tracks "state != IDLE" one flop earlier so the output is registered.
            halt_q    <= (state_d != S_IDLE);
`ifdef OAM_DMA_ALIGN_EN
            cyc_odd_q <= ~cyc_odd_q;
`endif
        end
    end

    assign cpu_halt   = halt_q;
    assign dma_active = halt_q;

endmodule
